// File: rtl/seg_scan_595_if.sv
// seg_scan_595_if
//   Display-data and handshake bundle between the frequency-counter result
//   logic (master) and the seven-segment scanner (slave).
//   master -> slave : digits, dps, blank_lz, load (+ bright with BRIGHTNESS_EN)
//   slave -> master : busy, frame_done, load_pending
//   Optional feature macro: BRIGHTNESS_EN adds the 3-bit bright field.
interface seg_scan_595_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dps;
  logic                    blank_lz;
  logic                    load;
`ifdef BRIGHTNESS_EN
  logic [2:0]              bright;
`endif
  logic                    busy;
  logic                    frame_done;
  logic                    load_pending;

`ifdef BRIGHTNESS_EN
  modport master (output digits, dps, blank_lz, load, bright,
                  input  busy, frame_done, load_pending);
  modport slave  (input  digits, dps, blank_lz, load, bright,
                  output busy, frame_done, load_pending);
`else
  modport master (output digits, dps, blank_lz, load,
                  input  busy, frame_done, load_pending);
  modport slave  (input  digits, dps, blank_lz, load,
                  output busy, frame_done, load_pending);
`endif
endinterface

// File: rtl/seg_scan_595.sv
// seg_scan_595
//   Scans 1..8 seven-segment digits through two cascaded 74HC595s. Each scan
//   slot shifts a 16-bit word {sel[7:0], seg[7:0]} MSB first, then pulses
//   rclk. Display data is double buffered: load captures into a shadow copy
//   that is applied only when the scan index wraps to digit 0, so a frame
//   never mixes old and new data.
//   Ports:
//     Clk, Reset_n       system clock, asynchronous active-low reset
//     bus (slave)        digits/dps/blank_lz/load in; busy/frame_done/
//                        load_pending out
//     dio, rclk, sclk    HC595 SER, storage clock, shift clock
//   Optional feature macro: BRIGHTNESS_EN -- adds bus.bright; once the
//   on-time inside a slot expires the blank word is shifted to dim the digit.
//
//   state | meaning
//   IDLE  | waiting for a slot tick (or a dimming request)
//   SHIFT | 16 bits out, sclk low then high for SCLK_DIV cycles each
//   LATCH | rclk low SCLK_DIV cycles (setup), then rclk high SCLK_DIV cycles
module seg_scan_595 #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int SCAN_FREQ      = 1000,
  parameter int SCLK_DIV       = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset_n,
  seg_scan_595_if.slave bus,
  output logic          dio,
  output logic          rclk,
  output logic          sclk
);

  localparam int SCAN_PERIOD = CLOCK_FREQ / SCAN_FREQ;
  localparam int CW = $clog2(SCAN_PERIOD);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_DIV - 1);
  localparam logic [7:0]  SEL_OFF    = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [15:0] BLANK_WORD = {SEL_OFF, SEG_OFF};

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t                  state;
  logic [CW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [PW-1:0]           phase;
  logic [3:0]              bit_cnt;
  logic [15:0]             word;
  logic                    last_digit;
  logic                    busy_r;
  logic                    frame_done_r;
  logic                    load_pending_r;
  logic                    valid;
  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
  logic [NUM_DIGITS-1:0]   sh_dps, act_dps;
  logic                    sh_blz, act_blz;
`ifdef BRIGHTNESS_EN
  logic [2:0]              sh_bright, act_bright;
  logic [31:0]             on_time;
`endif

  logic                    tick, take, wrap, boundary, dim_req;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dps;
  logic                    src_blz, src_valid;
  logic                    lz_run, blank_i, dp_i;
  logic [3:0]              dig_i;
  logic [7:0]              cur_seg, sel_onehot;
  logic [15:0]             digit_word, start_word;

  assign bus.busy         = busy_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.load_pending = load_pending_r;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // The word is built from the values that will be current after this edge,
  // so digit 0 of a new frame already shows the freshly copied shadow data.
  always_comb begin
    tick       = (scan_cnt == CW'(SCAN_PERIOD - 1));
    take       = tick && !busy_r;
    wrap       = (idx == IW'(NUM_DIGITS - 1));
    idx_nxt    = wrap ? '0 : idx + IW'(1);
    boundary   = take && wrap && load_pending_r;
    src_digits = boundary ? sh_digits : act_digits;
    src_dps    = boundary ? sh_dps    : act_dps;
    src_blz    = boundary ? sh_blz    : act_blz;
    src_valid  = boundary || valid;
  end

  // Leading-zero run walks down from the top digit; digit 0 always shows.
  always_comb begin
    lz_run  = src_blz;
    blank_i = 1'b0;
    dp_i    = 1'b0;
    dig_i   = 4'h0;
    cur_seg = 8'h00;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig_i   = src_digits[4*i +: 4];
      dp_i    = src_dps[i];
      blank_i = lz_run && (i != 0) && (dig_i == 4'h0) && !dp_i;
      if (!blank_i) lz_run = 1'b0;
      if (IW'(i) == idx_nxt) cur_seg = blank_i ? 8'h00 : {dp_i, hex7(dig_i)};
    end
  end

  always_comb begin
    sel_onehot = 8'd1 << idx_nxt;
    digit_word = {SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot,
                  SEG_ACTIVE_LOW ? ~cur_seg    : cur_seg};
    if (!src_valid) digit_word = BLANK_WORD;
    start_word = take ? digit_word : BLANK_WORD;
  end

`ifdef BRIGHTNESS_EN
  always_comb begin
    on_time = ((32'(act_bright) + 32'd1) * 32'(SCAN_PERIOD)) >> 3;
    dim_req = (act_bright != 3'd7) && !busy_r && (32'(scan_cnt) == on_time);
  end
`else
  assign dim_req = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      scan_cnt       <= '0;
      idx            <= '0;
      phase          <= '0;
      bit_cnt        <= 4'd0;
      word           <= 16'h0000;
      last_digit     <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      load_pending_r <= 1'b0;
      valid          <= 1'b0;
      sh_digits      <= '0;
      act_digits     <= '0;
      sh_dps         <= '0;
      act_dps        <= '0;
      sh_blz         <= 1'b0;
      act_blz        <= 1'b0;
`ifdef BRIGHTNESS_EN
      sh_bright      <= 3'd7;
      act_bright     <= 3'd7;
`endif
      dio            <= 1'b0;
      rclk           <= 1'b0;
      sclk           <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      scan_cnt     <= tick ? '0 : scan_cnt + CW'(1);

      if (bus.load) begin
        sh_digits      <= bus.digits;
        sh_dps         <= bus.dps;
        sh_blz         <= bus.blank_lz;
`ifdef BRIGHTNESS_EN
        sh_bright      <= bus.bright;
`endif
        load_pending_r <= 1'b1;
      end

      // A coincident load keeps the pending flag for the following frame.
      if (boundary) begin
        act_digits <= sh_digits;
        act_dps    <= sh_dps;
        act_blz    <= sh_blz;
`ifdef BRIGHTNESS_EN
        act_bright <= sh_bright;
`endif
        valid      <= 1'b1;
        if (!bus.load) load_pending_r <= 1'b0;
      end

      if (take) idx <= idx_nxt;

      case (state)
        IDLE: begin
          if (take || dim_req) begin
            state      <= SHIFT;
            busy_r     <= 1'b1;
            word       <= start_word;
            dio        <= start_word[15];
            sclk       <= 1'b0;
            phase      <= PHASE_LAST;
            bit_cnt    <= 4'd15;
            last_digit <= take && (idx_nxt == IW'(NUM_DIGITS - 1));
          end
        end
        SHIFT: begin
          if (phase != '0) begin
            phase <= phase - PW'(1);
          end else begin
            phase <= PHASE_LAST;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd0) begin
                state <= LATCH;
              end else begin
                bit_cnt <= bit_cnt - 4'd1;
                dio     <= word[bit_cnt - 4'd1];
              end
            end
          end
        end
        LATCH: begin
          if (phase != '0) begin
            phase <= phase - PW'(1);
          end else if (!rclk) begin
            rclk  <= 1'b1;
            phase <= PHASE_LAST;
          end else begin
            rclk         <= 1'b0;
            state        <= IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= last_digit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
